// File: rtl/bsg_mem_arb_pkg.sv
// Shared types and constants for the round-robin single-port memory arbiter.
// Types here describe the default configuration; the top rebuilds them from its own parameters.
package bsg_mem_arb_pkg;

    localparam int unsigned def_width_lp       = 8;
    localparam int unsigned def_els_lp         = 16;
    localparam int unsigned def_num_clients_lp = 2;
    localparam int unsigned def_addr_width_lp  = $clog2(def_els_lp);
    localparam int unsigned def_id_width_lp    = 1;

    // Last-grant pointer reset value: parking on the highest id gives client 0 first priority.
    localparam int unsigned def_reset_ptr_lp   = def_num_clients_lp - 1;

    typedef logic [def_id_width_lp-1:0] client_id_t;

    typedef struct packed {
        logic                         w;
        logic [def_addr_width_lp-1:0] addr;
        logic [def_width_lp-1:0]      data;
    } mem_req_t;

    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned reset_ptr(input int unsigned num_clients);
        return num_clients - 1;
    endfunction

endpackage

// File: rtl/bsg_arb_rr_select.sv
// Combinational round-robin pick: first requester strictly after last_id, wrapping to client 0.
module bsg_arb_rr_select
    import bsg_mem_arb_pkg::*;
#(
    parameter int unsigned num_clients_p = 2,
    parameter int unsigned id_width_lp   = safe_clog2(num_clients_p)
) (
    input  logic [num_clients_p-1:0] reqs,
    input  logic [id_width_lp-1:0]   last_id,
    output logic [num_clients_p-1:0] grant,
    output logic [id_width_lp-1:0]   grant_id
);

    localparam logic [num_clients_p-1:0] one_lp = {{(num_clients_p-1){1'b0}}, 1'b1};

    logic [num_clients_p-1:0] above_mask;
    logic [num_clients_p-1:0] above_reqs;
    logic [num_clients_p-1:0] pick;

    always_comb begin
        above_mask = '0;
        for (int i = 0; i < num_clients_p; i++) begin
            above_mask[i] = (i > int'(last_id));
        end
    end

    // Prefer requesters above the pointer; if none, wrap and take the lowest overall.
    assign above_reqs = reqs & above_mask;
    assign pick       = (|above_reqs) ? above_reqs : reqs;
    assign grant      = pick & (~pick + one_lp);

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < num_clients_p; i++) begin
            if (grant[i]) begin
                grant_id = id_width_lp'(i);
            end
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_arb.sv
// Round-robin arbiter sharing one synchronous single-port RAM among several requesters;
// read data comes back tagged with the requester id one cycle after the grant.
module bsg_mem_1rw_sync_arb
    import bsg_mem_arb_pkg::*;
#(
    parameter int unsigned width_p       = 8,
    parameter int unsigned els_p         = 16,
    parameter int unsigned num_clients_p = 2,
    parameter int unsigned addr_width_lp = safe_clog2(els_p),
    parameter int unsigned id_width_lp   = safe_clog2(num_clients_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_clients_p-1:0]               v_i,
    input  logic [num_clients_p-1:0]               w_i,
    input  logic [num_clients_p*addr_width_lp-1:0] addr_i,
    input  logic [num_clients_p*width_p-1:0]       data_i,
    output logic [num_clients_p-1:0]               yumi_o,
    output logic                                   resp_v_o,
    output logic [id_width_lp-1:0]                 resp_id_o,
    output logic [width_p-1:0]                     resp_data_o,
    output logic                                   mem_v_o,
    output logic                                   mem_w_o,
    output logic [addr_width_lp-1:0]               mem_addr_o,
    output logic [width_p-1:0]                     mem_data_o,
    input  logic [width_p-1:0]                     mem_data_i
);

    typedef struct packed {
        logic                     w;
        logic [addr_width_lp-1:0] addr;
        logic [width_p-1:0]       data;
    } req_t;

    localparam logic [id_width_lp-1:0] ptr_reset_lp = id_width_lp'(reset_ptr(num_clients_p));

    req_t                     reqs [num_clients_p];
    req_t                     mem_req;
    logic [num_clients_p-1:0] grant;
    logic [id_width_lp-1:0]   grant_id;
    logic                     grant_v;

    logic [id_width_lp-1:0]   ptr_q, ptr_d;
    logic                     resp_v_q, resp_v_d;
    logic [id_width_lp-1:0]   resp_id_q, resp_id_d;

    always_comb begin
        for (int i = 0; i < num_clients_p; i++) begin
            reqs[i].w    = w_i[i];
            reqs[i].addr = addr_i[i*addr_width_lp +: addr_width_lp];
            reqs[i].data = data_i[i*width_p +: width_p];
        end
    end

    bsg_arb_rr_select #(
        .num_clients_p (num_clients_p),
        .id_width_lp   (id_width_lp)
    ) u_select (
        .reqs     (v_i),
        .last_id  (ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign grant_v = |grant;

    // AND-OR mux keeps every memory field at zero when nobody is granted.
    always_comb begin
        mem_req = '0;
        for (int i = 0; i < num_clients_p; i++) begin
            if (grant[i]) begin
                mem_req = reqs[i];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        resp_id_d = resp_id_q;
        resp_v_d  = grant_v & ~mem_req.w;
        if (grant_v) begin
            ptr_d = grant_id;
        end
        if (grant_v && !mem_req.w) begin
            resp_id_d = grant_id;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q     <= ptr_reset_lp;
            resp_v_q  <= 1'b0;
            resp_id_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            resp_v_q  <= resp_v_d;
            resp_id_q <= resp_id_d;
        end
    end

    assign yumi_o      = grant;
    assign mem_v_o     = grant_v;
    assign mem_w_o     = mem_req.w;
    assign mem_addr_o  = mem_req.addr;
    assign mem_data_o  = mem_req.data;
    assign resp_v_o    = resp_v_q;
    assign resp_id_o   = resp_id_q;
    // The RAM is synchronous, so its output already lines up with resp_v_q.
    assign resp_data_o = mem_data_i;

`ifndef SYNTHESIS
    grant_onehot0_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(yumi_o));
    grant_needs_v_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (yumi_o & ~v_i) == '0);
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_arb.sv
// Scoreboard bench: a 2-client arbiter with a behavioural RAM, plus a 4-client arbiter for grant order.
module tb_bsg_mem_1rw_sync_arb;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // 2-client DUT
    logic [1:0]  v = '0, w = '0;
    logic [7:0]  addr = '0;
    logic [15:0] data = '0;
    logic [1:0]  yumi;
    logic        resp_v;
    logic [0:0]  resp_id;
    logic [7:0]  resp_data;
    logic        mem_v, mem_w;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata, ram_q;
    logic [7:0]  ram [16];

    // 4-client DUT
    logic [3:0]  v4 = '0, w4 = '0;
    logic [15:0] addr4 = '0;
    logic [31:0] data4 = '0;
    logic [3:0]  yumi4;
    logic        resp_v4;
    logic [1:0]  resp_id4;
    logic [7:0]  resp_data4;
    logic        mem_v4, mem_w4;
    logic [3:0]  mem_addr4;
    logic [7:0]  mem_wdata4;
    logic [7:0]  zero8 = '0;

    bsg_mem_1rw_sync_arb #(.width_p(8), .els_p(16), .num_clients_p(2)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .w_i(w), .addr_i(addr), .data_i(data),
        .yumi_o(yumi), .resp_v_o(resp_v), .resp_id_o(resp_id), .resp_data_o(resp_data),
        .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_data_i(ram_q)
    );

    bsg_mem_1rw_sync_arb #(.width_p(8), .els_p(16), .num_clients_p(4)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v4), .w_i(w4), .addr_i(addr4), .data_i(data4),
        .yumi_o(yumi4), .resp_v_o(resp_v4), .resp_id_o(resp_id4), .resp_data_o(resp_data4),
        .mem_v_o(mem_v4), .mem_w_o(mem_w4), .mem_addr_o(mem_addr4), .mem_data_o(mem_wdata4),
        .mem_data_i(zero8)
    );

    // Synchronous single-port RAM behind the 2-client arbiter.
    always @(posedge clk) begin
        if (mem_v) begin
            if (mem_w) ram[mem_addr] <= mem_wdata;
            else       ram_q <= ram[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [7:0] ref_mem [16];
    int ptr2 = 1;
    int ptr4 = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant(input int n, input int ptr, input logic [3:0] req);
        for (int i = 1; i <= n; i++) begin
            if (req[(ptr + i) % n]) return (ptr + i) % n;
        end
        return -1;
    endfunction

    // Drive one cycle on both DUTs, check the combinational grant, update the model.
    task automatic step(input logic [1:0] sv, input logic [1:0] sw, input logic [7:0] sa,
                        input logic [15:0] sd, input logic [3:0] s4v, input logic [3:0] s4w,
                        input logic [15:0] s4a, input logic [31:0] s4d);
        int g;
        int g4;
        logic [3:0] ea;
        logic [7:0] ed;
        exp_t e;
        @(negedge clk);
        v = sv; w = sw; addr = sa; data = sd;
        v4 = s4v; w4 = s4w; addr4 = s4a; data4 = s4d;
        #1;
        g = exp_grant(2, ptr2, {2'b00, sv});
        if (g < 0) begin
            chk("yumi_idle", {30'd0, yumi}, 0);
            chk("mem_v_idle", {31'd0, mem_v}, 0);
            chk("mem_w_idle", {31'd0, mem_w}, 0);
            chk("mem_addr_idle", {28'd0, mem_addr}, 0);
            chk("mem_data_idle", {24'd0, mem_wdata}, 0);
        end else begin
            ea = sa[g*4 +: 4];
            ed = sd[g*8 +: 8];
            chk("yumi", {30'd0, yumi}, 32'd1 << g);
            chk("mem_v", {31'd0, mem_v}, 1);
            chk("mem_w", {31'd0, mem_w}, {31'd0, sw[g]});
            chk("mem_addr", {28'd0, mem_addr}, {28'd0, ea});
            if (sw[g]) begin
                chk("mem_data", {24'd0, mem_wdata}, {24'd0, ed});
                ref_mem[ea] = ed;
            end else begin
                e.due = cyc + 1;
                e.id = g;
                e.data = ref_mem[ea];
                sb.push_back(e);
            end
            ptr2 = g;
        end
        g4 = exp_grant(4, ptr4, s4v);
        if (g4 < 0) begin
            chk("yumi4_idle", {28'd0, yumi4}, 0);
            chk("mem_v4_idle", {31'd0, mem_v4}, 0);
        end else begin
            chk("yumi4", {28'd0, yumi4}, 32'd1 << g4);
            chk("mem_addr4", {28'd0, mem_addr4}, {28'd0, s4a[g4*4 +: 4]});
            ptr4 = g4;
        end
    endtask

    // Monitor: every response must match the head of the scoreboard in its due cycle.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("resp_late", 0, 1);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("resp_v", {31'd0, resp_v}, 1);
            chk("resp_id", {31'd0, resp_id}, sb[0].id);
            chk("resp_data", {24'd0, resp_data}, {24'd0, sb[0].data});
            void'(sb.pop_front());
        end else if (resp_v !== 1'b0) begin
            chk("resp_spurious", {31'd0, resp_v}, 0);
        end
    end

    initial begin
        logic [31:0] r0, r1, r2, r3;
        logic [3:0] exp4 [4];
        exp4[0] = 4'b0010; exp4[1] = 4'b1000; exp4[2] = 4'b0010; exp4[3] = 4'b1000;

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_resp_v", {31'd0, resp_v}, 0);
        chk("reset_resp_id", {31'd0, resp_id}, 0);

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            step(2'b00, 2'b00, 8'h00, 16'h0000, 4'h0, 4'h0, 16'h0, 32'h0);
            chk("idle_resp_v", {31'd0, resp_v}, 0);
        end

        // Preload every word with its address via client 0 writes
        for (int k = 0; k < 16; k++) begin
            step(2'b01, 2'b01, {4'h0, 4'(k)}, {8'h00, 8'(k)}, 4'h0, 4'h0, 16'h0, 32'h0);
        end

        // Both clients read every cycle: grants alternate
        for (int k = 0; k < 8; k++) begin
            step(2'b11, 2'b00, {4'(k), 4'(7 - k)}, 16'h0, 4'h0, 4'h0, 16'h0, 32'h0);
        end

        // Write then read same address on back-to-back cycles
        step(2'b01, 2'b01, 8'h03, 16'h00A5, 4'h0, 4'h0, 16'h0, 32'h0);
        step(2'b10, 2'b00, 8'h30, 16'h0000, 4'h0, 4'h0, 16'h0, 32'h0);

        // 4-client: only 1 and 3 request from reset
        for (int k = 0; k < 4; k++) begin
            step(2'b00, 2'b00, 8'h00, 16'h0, 4'b1010, 4'h0, 16'h4321, 32'h0);
            chk("rr4_order", {28'd0, yumi4}, {28'd0, exp4[k]});
        end

        // Read granted to client 0, then reset pulsed before the next edge
        step(2'b01, 2'b00, 8'h05, 16'h0, 4'h0, 4'h0, 16'h0, 32'h0);
        @(posedge clk);
        #3;
        chk("pre_reset_resp_v", {31'd0, resp_v}, 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_resp_v", {31'd0, resp_v}, 0);
        chk("async_reset_resp_id", {31'd0, resp_id}, 0);
        reset_n = 1'b1;
        ptr2 = 1;
        ptr4 = 3;
        sb.delete();
        step(2'b11, 2'b00, 8'h21, 16'h0, 4'h0, 4'h0, 16'h0, 32'h0);
        chk("post_reset_priority", {30'd0, yumi}, 1);

        // Mixed random traffic
        for (int k = 0; k < 200; k++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            step(r0[1:0], r0[3:2], r0[15:8], r1[15:0], r0[19:16], r0[23:20], r2[15:0], r3);
            chk("onehot0", {31'd0, $onehot0(yumi)}, 1);
        end

        step(2'b00, 2'b00, 8'h00, 16'h0, 4'h0, 4'h0, 16'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
